// File: rtl/music_pkg.sv
// Shared music types: note/octave widths, packed note word and sequencer FSM states.
package music_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned OCT_W  = 2;

  typedef struct packed {
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
  } note_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StHold
  } seq_state_e;

endpackage

// File: rtl/note_sequencer_if.sv
// Record/playback bus of the note sequencer; master drives requests, slave is the sequencer.
interface note_sequencer_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NOTE_W = music_pkg::NOTE_W,
  parameter int unsigned OCT_W  = music_pkg::OCT_W
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic              rec_valid;
  logic [NOTE_W-1:0] rec_note;
  logic [OCT_W-1:0]  rec_octave;
  logic              rec_ready;
  logic              play_start;
  logic              play_stop;
  logic              loop_en;
  logic              clear;
  logic              play_valid;
  logic [NOTE_W-1:0] play_note;
  logic [OCT_W-1:0]  play_octave;
  logic [AW-1:0]     play_addr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              busy;

  modport master (
    output rec_valid, rec_note, rec_octave, play_start, play_stop, loop_en, clear,
    input  rec_ready, play_valid, play_note, play_octave, play_addr, count, full, empty, busy
  );

  modport slave (
    input  rec_valid, rec_note, rec_octave, play_start, play_stop, loop_en, clear,
    output rec_ready, play_valid, play_note, play_octave, play_addr, count, full, empty, busy
  );
endinterface

// File: rtl/seq_mem.sv
// Single-port synchronous RAM for note slots; one address shared by write and read.
module seq_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 6
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: records {octave, note} words into seq_mem and plays them back, each held
// for HOLD_TICKS cycles, optionally looping.
module note_sequencer
  import music_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NOTE_W     = music_pkg::NOTE_W,
  parameter int unsigned OCT_W      = music_pkg::OCT_W,
  parameter int unsigned HOLD_TICKS = 4
) (
  input logic              clk,
  input logic              reset,
  note_sequencer_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = NOTE_W + OCT_W;
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_TICKS - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_rdata;
  logic          idle, full, empty, rec_fire;
  logic [CW-1:0] next_addr;

  assign idle      = (state_q == StIdle);
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign rec_fire  = bus.rec_valid && idle && !full && !bus.clear;
  assign next_addr = {1'b0, addr_q} + CW'(1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = addr_q;

    if (bus.clear) begin
      state_d = StIdle;
      count_d = '0;
      addr_d  = '0;
      hold_d  = '0;
    end else if (bus.play_stop && !idle) begin
      state_d = StIdle;
      addr_d  = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.play_start && !empty) begin
            state_d = StRead;
            addr_d  = '0;
          end
          // Record uses the port now; the first READ is a cycle later, so no conflict.
          if (rec_fire) begin
            mem_we   = 1'b1;
            mem_addr = count_q[AW-1:0];
            count_d  = count_q + CW'(1);
          end
        end
        StRead: begin
          mem_re  = 1'b1;
          state_d = StHold;
          hold_d  = HoldLast;
        end
        StHold: begin
          if (hold_q == '0) begin
            if (next_addr < count_q) begin
              addr_d  = addr_q + AW'(1);
              state_d = StRead;
            end else if (bus.loop_en) begin
              addr_d  = '0;
              state_d = StRead;
            end else begin
              addr_d  = '0;
              state_d = StIdle;
            end
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  seq_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i ({bus.rec_octave, bus.rec_note}),
    .rdata_o (mem_rdata)
  );

  // Memory output is only meaningful in HOLD; gate it so the bus reads 0 elsewhere.
  always_comb begin
    bus.play_valid  = (state_q == StHold);
    bus.play_note   = '0;
    bus.play_octave = '0;
    if (state_q == StHold) begin
      bus.play_note   = mem_rdata[NOTE_W-1:0];
      bus.play_octave = mem_rdata[WW-1:NOTE_W];
    end
  end

  assign bus.play_addr = addr_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.busy      = !idle;
  assign bus.rec_ready = idle && !full && !bus.clear;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a per-cycle playback scoreboard.
module tb_note_sequencer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned HOLD  = 4;

  logic clk;
  logic reset;

  note_sequencer_if #(.DEPTH(DEPTH), .NOTE_W(4), .OCT_W(2)) bus ();

  note_sequencer #(
    .DEPTH      (DEPTH),
    .NOTE_W     (4),
    .OCT_W      (2),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] model [DEPTH];
  int         model_cnt = 0;
  logic [9:0] exp_q [$];
  int         first_cyc, last_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rec(input int n, input int o);
    bus.rec_valid  = 1'b1;
    bus.rec_note   = 4'(n);
    bus.rec_octave = 2'(o);
    if (model_cnt < DEPTH) begin
      model[model_cnt] = {2'(o), 4'(n)};
      model_cnt++;
    end
    tick();
    bus.rec_valid = 1'b0;
  endtask

  task automatic push_slots(input int first, input int n);
    for (int s = first; s < first + n; s++)
      for (int h = 0; h < int'(HOLD); h++)
        exp_q.push_back({4'(s), model[s]});
  endtask

  task automatic start_play(input logic loop);
    bus.loop_en    = loop;
    bus.play_start = 1'b1;
    tick();
    bus.play_start = 1'b0;
  endtask

  // Called right after the play_start edge; cycle 0 is READ of slot 0.
  task automatic run_play(output int f, output int l);
    logic [9:0] e;
    f = -1;
    l = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (bus.play_valid) begin
        if (f < 0) f = cyc;
        l = cyc;
        e = exp_q.pop_front();
        chk("play_slot", 32'({bus.play_addr, bus.play_octave, bus.play_note}), 32'(e));
      end else begin
        chk("gap_note_zero", 32'({bus.play_octave, bus.play_note}), 32'd0);
      end
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("play_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
    chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "_full"}, 32'(bus.full), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rec_ready"}, 32'(bus.rec_ready), 32'd1);
    chk({tag, "_play"}, 32'({bus.play_valid, bus.play_addr, bus.play_octave, bus.play_note}),
        32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.rec_valid  = 1'b0;
    bus.rec_note   = '0;
    bus.rec_octave = '0;
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;
    bus.loop_en    = 1'b0;
    bus.clear      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_reset_state("reset");

    // play_start while empty is ignored
    start_play(1'b0);
    chk("empty_start_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("empty_start_busy2", 32'(bus.busy), 32'd0);
    chk("empty_start_valid", 32'(bus.play_valid), 32'd0);

    // three notes, single pass
    rec(5, 1);
    rec(2, 0);
    rec(11, 3);
    chk("rec3_count", 32'(bus.count), 32'd3);
    chk("rec3_empty", 32'(bus.empty), 32'd0);
    push_slots(0, 3);
    start_play(1'b0);
    chk("read_busy", 32'(bus.busy), 32'd1);
    chk("read_rec_ready", 32'(bus.rec_ready), 32'd0);
    run_play(first_cyc, last_cyc);
    chk("latency", 32'(first_cyc), 32'd1);
    chk("last_hold_cyc", 32'(last_cyc), 32'd14);
    tick();
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_valid", 32'(bus.play_valid), 32'd0);

    // clear and play_start together during HOLD: clear wins
    start_play(1'b0);
    tick();
    tick();
    chk("hold_valid", 32'(bus.play_valid), 32'd1);
    bus.clear      = 1'b1;
    bus.play_start = 1'b1;
    chk("clear_rec_ready", 32'(bus.rec_ready), 32'd0);
    tick();
    bus.clear      = 1'b0;
    bus.play_start = 1'b0;
    model_cnt      = 0;
    chk("clear_busy", 32'(bus.busy), 32'd0);
    chk("clear_count", 32'(bus.count), 32'd0);
    chk("clear_empty", 32'(bus.empty), 32'd1);
    chk("clear_valid", 32'(bus.play_valid), 32'd0);

    // fill all slots, then a refused 17th record
    for (int i = 0; i < int'(DEPTH); i++) rec(int'($urandom_range(15)), int'($urandom_range(3)));
    chk("fill_count", 32'(bus.count), 32'(DEPTH));
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_rec_ready", 32'(bus.rec_ready), 32'd0);
    bus.rec_valid  = 1'b1;
    bus.rec_note   = ~model[0][3:0];
    bus.rec_octave = ~model[0][5:4];
    tick();
    bus.rec_valid = 1'b0;
    chk("over_count", 32'(bus.count), 32'(DEPTH));
    push_slots(0, DEPTH);
    start_play(1'b0);
    run_play(first_cyc, last_cyc);
    chk("full_last_cyc", 32'(last_cyc), 32'(1 + DEPTH * (HOLD + 1) - 2));
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_cnt = 0;

    // two notes looping, stop during the third note
    rec(9, 2);
    rec(3, 1);
    push_slots(0, 2);
    exp_q.push_back({4'd0, model[0]});
    exp_q.push_back({4'd0, model[0]});
    start_play(1'b1);
    run_play(first_cyc, last_cyc);
    chk("loop_last_cyc", 32'(last_cyc), 32'd12);
    bus.play_stop = 1'b1;
    tick();
    bus.play_stop = 1'b0;
    bus.loop_en   = 1'b0;
    chk("stop_valid", 32'(bus.play_valid), 32'd0);
    chk("stop_busy", 32'(bus.busy), 32'd0);
    chk("stop_note", 32'({bus.play_octave, bus.play_note}), 32'd0);
    chk("stop_count", 32'(bus.count), 32'd2);

    // reset during HOLD, then a record lands in slot 0
    start_play(1'b1);
    tick();
    tick();
    chk("pre_reset_valid", 32'(bus.play_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    model_cnt = 0;
    chk_reset_state("mid_reset");
    bus.loop_en = 1'b0;
    rec(7, 2);
    chk("post_reset_count", 32'(bus.count), 32'd1);
    push_slots(0, 1);
    start_play(1'b0);
    run_play(first_cyc, last_cyc);
    chk("post_reset_last", 32'(last_cyc), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of note slots; power of two, 4..256.
REQ-002 SHALL have parameter NOTE_W, default 4, note code width.
REQ-003 SHALL have parameter OCT_W, default 2, octave code width.
REQ-004 SHALL have parameter HOLD_TICKS, default 4, clk cycles each note is presented during playback; minimum 1.
REQ-005 SHALL have the following ports; one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- rec_valid  in  1  record request, qualified by rec_ready.
- rec_note  in  NOTE_W  note to record.
- rec_octave  in  OCT_W  octave to record.
- rec_ready  out  1  sequencer accepts a record this cycle.
- play_start  in  1  single-cycle pulse, begin playback.
- play_stop  in  1  single-cycle pulse, abort playback.
- loop_en  in  1  wrap to slot 0 after last note instead of stopping.
- clear  in  1  single-cycle pulse, empty the sequence.
- play_valid  out  1  play_note/play_octave hold a current note.
- play_note  out  NOTE_W  note being played.
- play_octave  out  OCT_W  octave being played.
- play_addr  out  log2(DEPTH)  slot being played.
- count  out  log2(DEPTH)+1  number of stored notes.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- busy  out  1  FSM not IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, READ, HOLD.
REQ-007 rec_ready SHALL be 1 only in IDLE with full == 0 and clear == 0.
REQ-008 A record (rec_valid & rec_ready) SHALL write {rec_octave, rec_note} to slot count and increment count by 1 at the same edge.
REQ-009 When full, records SHALL be refused (rec_ready 0); no wrap-around overwrite.
REQ-010 In IDLE, play_start with empty == 0 SHALL go to READ with play_addr = 0; with empty == 1, play_start SHALL be ignored.
REQ-011 READ SHALL last exactly 1 cycle (synchronous memory read), then go to HOLD with the hold counter loaded.
REQ-012 In HOLD, play_valid SHALL be 1 and play_note/play_octave SHALL equal the slot at play_addr for exactly HOLD_TICKS cycles.
REQ-013 At the end of HOLD: if play_addr < count-1, increment play_addr and go to READ; else if loop_en == 1, set play_addr = 0 and go to READ; else go to IDLE.
REQ-014 loop_en SHALL be sampled only at the last HOLD cycle of the last note.
REQ-015 Latency from play_start to first play_valid SHALL be 2 cycles.
REQ-016 play_stop in READ or HOLD SHALL force IDLE at the next edge with play_valid 0; it SHALL be ignored in IDLE.
REQ-017 clear SHALL set count to 0 and force IDLE at the next edge from any state; memory contents need not be erased.
REQ-018 Priority within one cycle SHALL be clear > play_stop > play_start > record.
REQ-019 Outside HOLD, play_valid SHALL be 0 and play_note/play_octave SHALL be 0.
REQ-020 full, empty and busy SHALL be decoded combinationally from registered state only.

Reset
REQ-021 At reset the FSM SHALL be IDLE; count, play_addr, play_valid, play_note, play_octave and the hold counter SHALL be 0. Therefore empty = 1, full = 0, busy = 0 and rec_ready = 1 the cycle after reset is released.
REQ-022 Reset mid-playback SHALL abort it at the same edge; memory contents SHALL be don't-care afterwards.

Structure
REQ-023 NOTE_W, OCT_W and a packed note struct {octave, note} type SHALL live in shared package music_pkg, reused by the frequency-select and VGA blocks.
REQ-024 Storage SHALL be a separate sub-module seq_mem: a single-port synchronous RAM, DEPTH x (NOTE_W+OCT_W), 1-cycle read latency, with write and read sharing the address mux.
REQ-025 The expected implementation size is 150-300 lines of RTL excluding seq_mem.

Verification
REQ-026 Record 3 notes (5/1, 2/0, 11/3), then play_start with loop_en = 0 and HOLD_TICKS = 4: play_valid rises 2 cycles later; the notes appear in order for 4 cycles each at play_addr 0,1,2; busy falls 1 cycle after the last hold.
REQ-027 Record 16 notes with DEPTH = 16: full = 1 and rec_ready = 0; a 17th rec_valid leaves count = 16 and slot 0 unchanged.
REQ-028 With 2 notes and loop_en = 1: the play_addr sequence is 0,1,0,1,...; assert play_stop during the third note: play_valid = 0 and busy = 0 one cycle later.
REQ-029 play_start with empty = 1: busy stays 0 and play_valid stays 0.
REQ-030 During HOLD, assert clear and play_start in the same cycle: the next cycle shows IDLE, count = 0 and empty = 1.
REQ-031 Assert reset in the middle of a HOLD: the next cycle shows all outputs at their REQ-021 values; a record then writes slot 0.
